// File: rtl/hp0_rd_arbiter.sv
// Round-robin arbiter sharing the PS HP0 AXI read channel between the two TLK2711
// transmit DMA read masters (0 = TLK2711-A, 1 = TLK2711-B), one burst at a time.
module hp0_rd_arbiter #(
   parameter int ADDR_WIDTH = 40,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [1:0]              m_arvalid,
   output logic [1:0]              m_arready,
   input  logic [2*ADDR_WIDTH-1:0] m_araddr,
   input  logic [15:0]             m_arlen,
   output logic [1:0]              m_rvalid,
   input  logic [1:0]              m_rready,
   output logic [DATA_WIDTH-1:0]   m_rdata,
   output logic [1:0]              m_rresp,
   output logic                    m_rlast,
   output logic                    s_arvalid,
   input  logic                    s_arready,
   output logic [ADDR_WIDTH-1:0]   s_araddr,
   output logic [7:0]              s_arlen,
   output logic [ID_WIDTH-1:0]     s_arid,
   input  logic                    s_rvalid,
   output logic                    s_rready,
   input  logic [DATA_WIDTH-1:0]   s_rdata,
   input  logic [1:0]              s_rresp,
   input  logic                    s_rlast,
   output logic [1:0]              o_grant,
   output logic [1:0]              o_err,
   input  logic                    i_err_clr,
   output logic [1:0]              dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic       g, g_nxt;
   logic       last_grant;
   logic [7:0] len_q;
   logic [7:0] beat_cnt;
   logic [1:0] err_set;
   logic       ar_hs;
   logic       r_hs;

   // Handshake rules on both sides: a transfer happens on a rising clk edge where
   // valid and ready are both high; valid never waits on ready.
   assign m_rdata   = s_rdata;
   assign m_rresp   = s_rresp;
   assign m_rlast   = s_rlast;
   assign s_araddr  = g ? m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_araddr[ADDR_WIDTH-1:0];
   assign s_arlen   = g ? m_arlen[15:8] : m_arlen[7:0];
   assign s_arid    = {{(ID_WIDTH-1){1'b0}}, g};
   assign dbg_state = state;

   always_comb begin
      state_nxt = state;
      g_nxt     = g;
      s_arvalid = 1'b0;
      m_arready = 2'b00;
      m_rvalid  = 2'b00;
      s_rready  = 1'b0;
      err_set   = 2'b00;
      ar_hs     = 1'b0;
      r_hs      = 1'b0;
      case (state)
         IDLE: begin
            case (m_arvalid)
               2'b01:   begin g_nxt = 1'b0;        state_nxt = ADDR; end
               2'b10:   begin g_nxt = 1'b1;        state_nxt = ADDR; end
               2'b11:   begin g_nxt = ~last_grant; state_nxt = ADDR; end
               default: ;
            endcase
         end
         ADDR: begin
            s_arvalid    = m_arvalid[g];
            m_arready[g] = s_arready;
            ar_hs        = m_arvalid[g] & s_arready;
            if (ar_hs) state_nxt = DATA;
         end
         DATA: begin
            m_rvalid[g] = s_rvalid;
            s_rready    = m_rready[g];
            r_hs        = s_rvalid & m_rready[g];
            // beat_cnt holds beats already accepted, so the final beat must see len_q
            if (r_hs) begin
               if (s_rlast) begin
                  if (beat_cnt != len_q) err_set[g] = 1'b1;
                  state_nxt = IDLE;
               end else if (beat_cnt == len_q) begin
                  err_set[g] = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         g          <= 1'b0;
         last_grant <= 1'b1;
         len_q      <= 8'd0;
         beat_cnt   <= 8'd0;
         o_err      <= 2'b00;
         o_grant    <= 2'b00;
      end else begin
         state   <= state_nxt;
         g       <= g_nxt;
         o_grant <= (state_nxt == IDLE) ? 2'b00 : (g_nxt ? 2'b10 : 2'b01);
         // a new error in the same cycle as a clear request is kept
         o_err   <= (i_err_clr ? 2'b00 : o_err) | err_set;
         if (ar_hs) begin
            len_q    <= s_arlen;
            beat_cnt <= 8'd0;
         end
         if (r_hs) begin
            if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
            if (s_rlast) last_grant <= g;
         end
      end
   end

endmodule

// File: tb/tb_hp0_rd_arbiter.sv
// Directed bench for hp0_rd_arbiter: the bench plays both DMA masters and the HP0 slave.
module tb_hp0_rd_arbiter;
   localparam int AW = 40;
   localparam int DW = 64;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [1:0]      m_arvalid = '0;
   logic [1:0]      m_arready;
   logic [2*AW-1:0] m_araddr = '0;
   logic [15:0]     m_arlen = '0;
   logic [1:0]      m_rvalid;
   logic [1:0]      m_rready = '0;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rlast;
   logic            s_arvalid;
   logic            s_arready = 1'b1;
   logic [AW-1:0]   s_araddr;
   logic [7:0]      s_arlen;
   logic [IW-1:0]   s_arid;
   logic            s_rvalid = 1'b0;
   logic            s_rready;
   logic [DW-1:0]   s_rdata = '0;
   logic [1:0]      s_rresp = '0;
   logic            s_rlast = 1'b0;
   logic [1:0]      o_grant;
   logic [1:0]      o_err;
   logic            i_err_clr = 1'b0;
   logic [1:0]      dbg_state;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];

   hp0_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rstn(rstn),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rlast(m_rlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arid(s_arid), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast),
      .o_grant(o_grant), .o_err(o_err), .i_err_clr(i_err_clr), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int m, input logic [AW-1:0] addr, input logic [7:0] len);
      m_araddr[m*AW +: AW] = addr;
      m_arlen[m*8 +: 8]    = len;
      m_arvalid[m]         = 1'b1;
   endtask

   // Raise a request and wait (bounded) until the arbiter presents it, then complete
   // the address handshake. Returns the cycle count from request to s_arvalid.
   task automatic addr_phase(input int m, input logic [AW-1:0] addr, input logic [7:0] len,
                             output int lat);
      lat = 0;
      set_req(m, addr, len);
      #1;
      while (!(s_arvalid === 1'b1 && s_arready === 1'b1 && s_arid == IW'(m)) && lat < 50) begin
         tick();
         lat++;
      end
      if (lat >= 50) begin
         errors++;
         $display("FAIL addr_wait: master %0d never presented (s_arvalid=%b)", m, s_arvalid);
      end
      tick();
      m_arvalid[m] = 1'b0;
   endtask

   // Slave returns nbeats beats (rlast on the last); master m accepts, optionally
   // on alternate cycles. Accepted data goes to got_q.
   task automatic data_phase(input int m, input int nbeats, input bit toggle,
                             input logic [DW-1:0] base, input logic [1:0] resp,
                             output int beats, output int route_err, output int track_err);
      int cyc;
      logic [1:0] exp_v;
      exp_v     = (m == 0) ? 2'b01 : 2'b10;
      beats     = 0;
      route_err = 0;
      track_err = 0;
      cyc       = 0;
      while (beats < nbeats && cyc < 100) begin
         s_rvalid = 1'b1;
         s_rdata  = base + DW'(beats);
         s_rresp  = resp;
         s_rlast  = (beats == nbeats - 1);
         m_rready[m]     = toggle ? (cyc % 2 == 0) : 1'b1;
         m_rready[1 - m] = ~m_rready[m];
         #1;
         if (s_rready !== m_rready[m]) track_err++;
         if (m_rvalid !== exp_v) route_err++;
         if (m_rdata !== s_rdata || m_rresp !== resp || m_rlast !== s_rlast) route_err++;
         if (s_rready === 1'b1) begin
            got_q.push_back(m_rdata);
            beats++;
         end
         tick();
         cyc++;
      end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      m_rready = 2'b00;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      checks++;
      if ({o_grant, o_err, s_arvalid, m_arready, m_rvalid, s_rready} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs: got grant=%b err=%b arvalid=%b arready=%b rvalid=%b rready=%b, want all 0",
                  o_grant, o_err, s_arvalid, m_arready, m_rvalid, s_rready);
      end
      checks++;
      if (dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d want 0", dbg_state);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_simultaneous();
      int beats, rerr, terr;
      set_req(0, 40'h00_0000_1000, 8'd0);
      set_req(1, 40'h00_0000_2000, 8'd0);
      tick();
      checks++;
      if (o_grant !== 2'b01 || s_arid !== 4'd0 || s_araddr !== 40'h00_0000_1000) begin
         errors++;
         $display("FAIL simul_first: got grant=%b arid=%0d addr=%h want 01/0/0000001000",
                  o_grant, s_arid, s_araddr);
      end
      tick();
      m_arvalid[0] = 1'b0;
      data_phase(0, 1, 1'b0, 64'hA0, 2'b00, beats, rerr, terr);
      checks++;
      if (o_grant !== 2'b00 || beats != 1 || rerr != 0) begin
         errors++;
         $display("FAIL simul_idle: got grant=%b beats=%0d route_err=%0d want 00/1/0", o_grant, beats, rerr);
      end
      tick();
      checks++;
      if (o_grant !== 2'b10 || s_arid !== 4'd1 || s_araddr !== 40'h00_0000_2000) begin
         errors++;
         $display("FAIL simul_second: got grant=%b arid=%0d addr=%h want 10/1/0000002000",
                  o_grant, s_arid, s_araddr);
      end
      tick();
      m_arvalid[1] = 1'b0;
      data_phase(1, 1, 1'b0, 64'hB0, 2'b00, beats, rerr, terr);
      checks++;
      if (o_err !== 2'b00 || rerr != 0) begin
         errors++;
         $display("FAIL simul_len0_err: got err=%b route_err=%0d want 00/0", o_err, rerr);
      end
      got_q.delete();
   endtask

   task automatic test_back_to_back();
      int beats, rerr, terr, cyc, eg;
      set_req(0, 40'h00_0000_3000, 8'd1);
      set_req(1, 40'h00_0000_4000, 8'd1);
      for (int b = 0; b < 4; b++) begin
         eg  = b % 2;
         cyc = 0;
         while (dbg_state !== 2'd1 && cyc < 20) begin
            tick();
            cyc++;
         end
         checks++;
         if (o_grant !== ((eg == 0) ? 2'b01 : 2'b10) || s_arid !== IW'(eg)) begin
            errors++;
            $display("FAIL b2b_grant%0d: got grant=%b arid=%0d want master %0d", b, o_grant, s_arid, eg);
         end
         tick();
         if (eg == 0) m_arvalid[0] = 1'b0;
         data_phase(eg, 2, 1'b0, 64'hC0, 2'b00, beats, rerr, terr);
         checks++;
         if (beats != 2 || rerr != 0) begin
            errors++;
            $display("FAIL b2b_data%0d: got beats=%0d route_err=%0d want 2/0", b, beats, rerr);
         end
         m_arvalid[0] = 1'b1;
      end
      m_arvalid = 2'b00;
      got_q.delete();
   endtask

   task automatic test_single();
      int beats, rerr, terr;
      set_req(0, 40'h10_0000_0000, 8'd3);
      #1;
      checks++;
      if (s_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL single_latency: got s_arvalid=%b in the request cycle, want 0", s_arvalid);
      end
      tick();
      checks++;
      if (s_arvalid !== 1'b1 || s_arid !== 4'd0 || s_araddr !== 40'h10_0000_0000 ||
          s_arlen !== 8'd3 || o_grant !== 2'b01 || m_arready !== 2'b01) begin
         errors++;
         $display("FAIL single_addr: got arvalid=%b arid=%0d addr=%h len=%0d grant=%b arready=%b want 1/0/1000000000/3/01/01",
                  s_arvalid, s_arid, s_araddr, s_arlen, o_grant, m_arready);
      end
      tick();
      m_arvalid[0] = 1'b0;
      for (int k = 0; k < 4; k++) exp_q.push_back(64'h5100 + DW'(k));
      data_phase(0, 4, 1'b0, 64'h5100, 2'b10, beats, rerr, terr);
      checks++;
      if (beats != 4 || rerr != 0 || o_err !== 2'b00 || dbg_state !== 2'd0 || o_grant !== 2'b00) begin
         errors++;
         $display("FAIL single_burst: got beats=%0d route_err=%0d err=%b state=%0d grant=%b want 4/0/00/0/00",
                  beats, rerr, o_err, dbg_state, o_grant);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL single_count: got %0d beats want %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [DW-1:0] e, a;
         e = exp_q.pop_front();
         a = got_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL single_data: got %h want %h", a, e);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_backpressure();
      int beats, rerr, terr;
      s_arready = 1'b0;
      set_req(0, 40'h00_0000_8000, 8'd7);
      tick();
      checks++;
      if (s_arvalid !== 1'b1 || m_arready !== 2'b00) begin
         errors++;
         $display("FAIL bp_stall: got arvalid=%b arready=%b want 1/00", s_arvalid, m_arready);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (s_arvalid !== 1'b1 || dbg_state !== 2'd1) begin
         errors++;
         $display("FAIL bp_hold: got arvalid=%b state=%0d want 1/1", s_arvalid, dbg_state);
      end
      s_arready = 1'b1;
      #1;
      checks++;
      if (m_arready !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: got arready=%b want 01", m_arready);
      end
      tick();
      m_arvalid[0] = 1'b0;
      for (int k = 0; k < 8; k++) exp_q.push_back(64'h7700 + DW'(k));
      data_phase(0, 8, 1'b1, 64'h7700, 2'b00, beats, rerr, terr);
      checks++;
      if (beats != 8 || rerr != 0 || terr != 0 || o_err !== 2'b00 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL bp_burst: got beats=%0d route_err=%0d track_err=%0d err=%b state=%0d want 8/0/0/00/0",
                  beats, rerr, terr, o_err, dbg_state);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_count: got %0d beats want %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [DW-1:0] e, a;
         e = exp_q.pop_front();
         a = got_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL bp_data: got %h want %h", a, e);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_short_burst();
      int beats, rerr, terr, lat;
      addr_phase(0, 40'h00_0000_9000, 8'd3, lat);
      data_phase(0, 2, 1'b0, 64'h9900, 2'b00, beats, rerr, terr);
      checks++;
      if (o_err !== 2'b01 || dbg_state !== 2'd0 || o_grant !== 2'b00) begin
         errors++;
         $display("FAIL short_err: got err=%b state=%0d grant=%b want 01/0/00", o_err, dbg_state, o_grant);
      end
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      checks++;
      if (o_err !== 2'b00) begin
         errors++;
         $display("FAIL short_clear: got err=%b want 00", o_err);
      end
      got_q.delete();
   endtask

   task automatic test_err_priority();
      int beats, rerr, terr, lat;
      addr_phase(1, 40'h00_0000_A000, 8'd0, lat);
      i_err_clr = 1'b1;
      data_phase(1, 2, 1'b0, 64'hAA00, 2'b11, beats, rerr, terr);
      i_err_clr = 1'b0;
      checks++;
      if (o_err !== 2'b10 || beats != 2 || rerr != 0) begin
         errors++;
         $display("FAIL overrun_set_wins: got err=%b beats=%0d route_err=%0d want 10/2/0", o_err, beats, rerr);
      end
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      got_q.delete();
   endtask

   task automatic test_reset_mid();
      int beats, rerr, terr, lat;
      addr_phase(0, 40'h00_0000_B000, 8'd3, lat);
      s_rvalid    = 1'b1;
      s_rdata     = 64'hBB00;
      m_rready[0] = 1'b1;
      tick();
      s_rdata = 64'hBB01;
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if (s_rready !== 1'b0 || m_rvalid !== 2'b00 || o_grant !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid: got rready=%b rvalid=%b grant=%b want 0/00/00", s_rready, m_rvalid, o_grant);
      end
      s_rvalid = 1'b0;
      m_rready = 2'b00;
      tick();
      rstn = 1'b1;
      tick();
      set_req(0, 40'h00_0000_C000, 8'd0);
      set_req(1, 40'h00_0000_D000, 8'd0);
      tick();
      checks++;
      if (o_grant !== 2'b01 || s_arid !== 4'd0) begin
         errors++;
         $display("FAIL reset_regrant: got grant=%b arid=%0d want 01/0", o_grant, s_arid);
      end
      tick();
      m_arvalid = 2'b00;
      data_phase(0, 1, 1'b0, 64'hCC00, 2'b00, beats, rerr, terr);
      got_q.delete();
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_back_to_back();
      test_single();
      test_backpressure();
      test_short_burst();
      test_err_priority();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
